counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter_pkg.sv | 17 +
 rtl/counter_arbiter_rr_arbiter.sv | 30 +++
 rtl/counter_arbiter.sv | 141 ++++++++++++++
 tb/tb_counter_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_arbiter_pkg.sv
// Shared types for the counter arbiter: the per-requester operation encoding
// and the two-state control FSM.
package counter_arbiter_pkg;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        LOAD = 2'd1,
        INC  = 2'd2,
        DEC  = 2'd3
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// Round-robin winner selection: the first asserted request at or above ptr,
// wrapping around, reported both one-hot and as an index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    // Scan from ptr upwards modulo N and stop at the first active request.
    always_comb begin
        int cand;
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// Shared counter with N_REQ round-robin requesters. A granted op is latched
// in IDLE, applied at the end of the single EXEC cycle, and reported by a
// one-cycle done pulse. Define COUNTER_ARBITER_SATURATE_EN to make INC/DEC
// saturate at the range limits instead of wrapping; ovf is set either way.
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset_,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [2*N_REQ-1:0]         req_op,
    input  logic [WIDTH*N_REQ-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic [WIDTH-1:0]           count,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(N_REQ)-1:0]   done_id,
    output logic                       ovf
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t            state;
    op_t               lat_op;
    logic [WIDTH-1:0]  lat_data;
    logic [IDX_W-1:0]  lat_idx;
    logic [IDX_W-1:0]  rr_ptr;

    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  win_idx;
    logic              win_any;
    op_t               win_op;
    logic [WIDTH-1:0]  win_data;
    logic [WIDTH-1:0]  next_count;
    logic              next_ovf;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .index (win_idx),
        .any   (win_any)
    );

    // The strobe is gated by reset_ so nothing is accepted while reset is held.
    assign req_ready = (state == IDLE && reset_) ? grant : '0;
    assign busy      = (state == EXEC);

    // Pick the winning requester's op and load value off the packed buses.
    always_comb begin
        win_op   = NOP;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_op   = op_t'(req_op[2*i +: 2]);
                win_data = req_data[WIDTH*i +: WIDTH];
            end
        end
    end

    // Result of applying the latched op; boundary hits raise ovf.
    always_comb begin
        next_count = count;
        next_ovf   = ovf;
        case (lat_op)
            LOAD: begin
                next_count = lat_data;
                next_ovf   = 1'b0;
            end
            INC: begin
                if (count == '1) begin
                    next_ovf = 1'b1;
`ifdef COUNTER_ARBITER_SATURATE_EN
                    next_count = count;
`else
                    next_count = '0;
`endif
                end else begin
                    next_count = count + WIDTH'(1);
                end
            end
            DEC: begin
                if (count == '0) begin
                    next_ovf = 1'b1;
`ifdef COUNTER_ARBITER_SATURATE_EN
                    next_count = count;
`else
                    next_count = '1;
`endif
                end else begin
                    next_count = count - WIDTH'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Control FSM: latch the grant in IDLE, commit and report it in EXEC.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state    <= IDLE;
            lat_op   <= NOP;
            lat_data <= '0;
            lat_idx  <= '0;
            rr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
            done_id  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        lat_op   <= win_op;
                        lat_data <= win_data;
                        lat_idx  <= win_idx;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    count   <= next_count;
                    ovf     <= next_ovf;
                    rr_ptr  <= (lat_idx == IDX_W'(N_REQ - 1)) ? '0 : lat_idx + IDX_W'(1);
                    done    <= 1'b1;
                    done_id <= lat_idx;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter (N_REQ=4, WIDTH=16). A reference
// model predicts the winner and the resulting count/ovf when each request is
// driven; the prediction is queued and compared when done pulses.
module tb_counter_arbiter;
    import counter_arbiter_pkg::*;

    typedef struct {
        int          id;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    logic        clock;
    logic        reset_;
    logic [3:0]  req_valid;
    logic [7:0]  req_op;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic        ovf;

    int vectors;
    int miscompares;
    int cyc;
    int last_done_cyc;

    op_t         op_a[4];
    logic [15:0] data_a[4];

    logic [15:0] model_count;
    logic        model_ovf;
    int          model_ptr;
    exp_t        sb[$];

    counter_arbiter #(
        .N_REQ (4),
        .WIDTH (16)
    ) dut (
        .clock     (clock),
        .reset_    (reset_),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_ready (req_ready),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .ovf       (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int model_winner(input logic [3:0] v);
        int c;
        for (int i = 0; i < 4; i++) begin
            c = (model_ptr + i) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_step(input op_t op, input logic [15:0] d);
        case (op)
            LOAD: begin
                model_count = d;
                model_ovf   = 1'b0;
            end
            INC: begin
                if (model_count == 16'hFFFF) begin
                    model_ovf = 1'b1;
`ifndef COUNTER_ARBITER_SATURATE_EN
                    model_count = 16'h0000;
`endif
                end else model_count = model_count + 16'd1;
            end
            DEC: begin
                if (model_count == 16'h0000) begin
                    model_ovf = 1'b1;
`ifndef COUNTER_ARBITER_SATURATE_EN
                    model_count = 16'hFFFF;
`endif
                end else model_count = model_count - 16'd1;
            end
            default: begin
            end
        endcase
    endfunction

    task automatic drive_bus();
        for (int i = 0; i < 4; i++) begin
            req_op[2*i +: 2]    = op_a[i];
            req_data[16*i +: 16] = data_a[i];
        end
    endtask

    task automatic apply_reset();
        req_valid = 4'b0000;
        reset_    = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_      = 1'b1;
        model_count = 16'h0000;
        model_ovf   = 1'b0;
        model_ptr   = 0;
        sb.delete();
    endtask

    // One arbitration round: present v, check the grant, predict the result,
    // optionally drop the request mid-EXEC, then compare when done pulses.
    task automatic run_op(input logic [3:0] v, input bit drop, input string tag);
        int          w;
        exp_t        e;
        exp_t        got_e;
        bit          got;
        int          waited;
        logic [3:0]  exp_ready;
        @(negedge clock);
        drive_bus();
        req_valid = v;
        #1;
        w         = model_winner(v);
        exp_ready = 4'b0001 << w;
        vectors++;
        if (req_ready !== exp_ready) begin
            miscompares++;
            $display("[TB] FAIL %s ready: got %b expected %b", tag, req_ready, exp_ready);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s busy_idle: got %b expected 0", tag, busy);
        end
        model_step(op_a[w], data_a[w]);
        e.id  = w;
        e.cnt = model_count;
        e.ovf = model_ovf;
        sb.push_back(e);
        model_ptr = (w + 1) % 4;
        @(posedge clock);
        #1;
        vectors++;
        if (busy !== 1'b1 || req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL %s exec: busy %b ready %b expected busy 1 ready 0000", tag, busy, req_ready);
        end
        if (drop) begin
            req_valid = 4'b0000;
            req_op    = ~req_op;
            req_data  = ~req_data;
        end
        got    = 1'b0;
        waited = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(posedge clock);
            #1;
            waited++;
            if (done === 1'b1) got = 1'b1;
        end
        got_e = sb.pop_front();
        vectors++;
        if (!got || waited != 1) begin
            miscompares++;
            $display("[TB] FAIL %s latency: done after %0d edges (seen %b) expected 1", tag, waited, got);
        end else begin
            last_done_cyc = cyc;
            vectors++;
            if (count !== got_e.cnt) begin
                miscompares++;
                $display("[TB] FAIL %s count: got %h expected %h", tag, count, got_e.cnt);
            end
            vectors++;
            if (int'(done_id) != got_e.id) begin
                miscompares++;
                $display("[TB] FAIL %s done_id: got %0d expected %0d", tag, done_id, got_e.id);
            end
            vectors++;
            if (ovf !== got_e.ovf) begin
                miscompares++;
                $display("[TB] FAIL %s ovf: got %b expected %b", tag, ovf, got_e.ovf);
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            op_a[i]   = LOAD;
            data_a[i] = 16'h1111 * (i + 1);
        end
        drive_bus();
        reset_    = 1'b0;
        req_valid = 4'b1111;
        @(negedge clock);
        @(posedge clock);
        #1;
        vectors++;
        if (count !== 16'h0000 || busy !== 1'b0 || ovf !== 1'b0 || done !== 1'b0 ||
            done_id !== 2'd0 || req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_values: count %h busy %b ovf %b done %b id %0d ready %b expected all zero",
                     count, busy, ovf, done, done_id, req_ready);
        end
        @(negedge clock);
        req_valid = 4'b0000;
        reset_    = 1'b1;
        model_count = 16'h0000;
        model_ovf   = 1'b0;
        model_ptr   = 0;
        sb.delete();

        op_a[0]   = LOAD;
        data_a[0] = 16'h0042;
        run_op(4'b0001, 1'b0, "reset_preload");

        op_a[1] = INC;
        @(negedge clock);
        drive_bus();
        req_valid = 4'b0010;
        @(posedge clock);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_enter_exec: busy %b expected 1", busy);
        end
        #2;
        req_valid = 4'b0000;
        reset_    = 1'b0;
        #1;
        vectors++;
        if (count !== 16'h0000 || busy !== 1'b0 || ovf !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_exec: count %h busy %b ovf %b done %b expected 0000 0 0 0",
                     count, busy, ovf, done);
        end
        @(negedge clock);
        reset_      = 1'b1;
        model_count = 16'h0000;
        model_ovf   = 1'b0;
        model_ptr   = 0;
        sb.delete();
        @(posedge clock);
        @(posedge clock);
        #1;
        vectors++;
        if (count !== 16'h0000 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_discard: count %h done %b expected 0000 0", count, done);
        end
    endtask

    task automatic test_single_load();
        op_a[0]   = LOAD;
        data_a[0] = 16'h1234;
        run_op(4'b0001, 1'b1, "single_load");
        vectors++;
        if (count !== 16'h1234 || done_id !== 2'd0 || done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_load_const: count %h id %0d done %b expected 1234 0 1", count, done_id, done);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_pulse_width: done %b expected 0", done);
        end
    endtask

    task automatic test_fairness();
        int exp_id[5];
        int prev;
        exp_id = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int i = 0; i < 4; i++) op_a[i] = INC;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            run_op(4'b1111, 1'b0, "fairness");
            vectors++;
            if (int'(done_id) != exp_id[k] || count !== 16'(k + 1)) begin
                miscompares++;
                $display("[TB] FAIL fairness_order[%0d]: id %0d count %h expected id %0d count %h",
                         k, done_id, count, exp_id[k], 16'(k + 1));
            end
            if (k > 0) begin
                vectors++;
                if (last_done_cyc - prev != 2) begin
                    miscompares++;
                    $display("[TB] FAIL fairness_spacing[%0d]: %0d cycles expected 2", k, last_done_cyc - prev);
                end
            end
            prev = last_done_cyc;
        end
    endtask

    task automatic test_ptr_wrap();
        op_a[2]   = DEC;
        op_a[3]   = LOAD;
        data_a[3] = 16'hBEEF;
        run_op(4'b0100, 1'b0, "ptr_to_3");
        run_op(4'b0100, 1'b0, "ptr_wrap_req2");
        run_op(4'b1100, 1'b0, "ptr_stays_3");
        vectors++;
        if (done_id !== 2'd3 || count !== 16'hBEEF) begin
            miscompares++;
            $display("[TB] FAIL ptr_wrap_const: id %0d count %h expected 3 beef", done_id, count);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_c;
`ifdef COUNTER_ARBITER_SATURATE_EN
        exp_c = 16'hFFFF;
`else
        exp_c = 16'h0000;
`endif
        op_a[0]   = LOAD;
        data_a[0] = 16'hFFFF;
        run_op(4'b0001, 1'b0, "ovf_preload");
        op_a[1] = INC;
        run_op(4'b0010, 1'b0, "ovf_inc");
        vectors++;
        if (count !== exp_c || ovf !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ovf_inc_const: count %h ovf %b expected %h 1", count, ovf, exp_c);
        end
        op_a[2]   = LOAD;
        data_a[2] = 16'h0005;
        run_op(4'b0100, 1'b0, "ovf_clear");
        vectors++;
        if (count !== 16'h0005 || ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_clear_const: count %h ovf %b expected 0005 0", count, ovf);
        end
    endtask

    task automatic test_underflow();
        logic [15:0] exp_c;
`ifdef COUNTER_ARBITER_SATURATE_EN
        exp_c = 16'h0000;
`else
        exp_c = 16'hFFFF;
`endif
        op_a[3]   = LOAD;
        data_a[3] = 16'h0000;
        run_op(4'b1000, 1'b0, "udf_preload");
        op_a[0] = DEC;
        run_op(4'b0001, 1'b0, "udf_dec");
        vectors++;
        if (count !== exp_c || ovf !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL udf_dec_const: count %h ovf %b expected %h 1", count, ovf, exp_c);
        end
        op_a[1] = NOP;
        run_op(4'b0010, 1'b0, "udf_nop");
        vectors++;
        if (count !== exp_c || done !== 1'b1 || done_id !== 2'd1 || ovf !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL nop_const: count %h done %b id %0d ovf %b expected %h 1 1 1",
                     count, done, done_id, ovf, exp_c);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            op_a[i]   = op_t'($urandom_range(0, 3));
            data_a[i] = 16'($urandom);
        end
        for (int k = 0; k < 12; k++) begin
            logic [3:0] v;
            v = 4'($urandom_range(1, 15));
            run_op(v, k[0], "back_to_back");
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        cyc           = 0;
        last_done_cyc = 0;
        reset_        = 1'b0;
        req_valid     = 4'b0000;
        req_op        = '0;
        req_data      = '0;
        model_count   = 16'h0000;
        model_ovf     = 1'b0;
        model_ptr     = 0;

        test_reset();
        test_single_load();
        test_fairness();
        test_ptr_wrap();
        test_overflow();
        test_underflow();
        test_back_to_back();

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
